// File: rtl/uart_tx.sv
// 8N1 RS-232 transmitter with a one-entry holding register, so a queued byte
// follows the previous stop bit with no idle gap.
module uart_tx #(
  parameter int CLKS_PER_BIT = 1250
) (
  input  logic       CLK_i,
  input  logic       RSTn_i,
  input  logic [7:0] TX_DATA_i,
  input  logic       TX_VALID_i,
  output logic       TX_READY_o,
  output logic       RS232_TX_o,
  output logic       TX_BUSY_o
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]    r_state;
  logic [7:0]    r_hold_data;
  logic          r_hold_full;
  logic [7:0]    r_shift;
  logic [CW-1:0] r_baud_cnt;
  logic [2:0]    r_bit_idx;
  logic          r_tx;

  logic [1:0]    w_state_n;
  logic [7:0]    w_shift_n;
  logic [CW-1:0] w_cnt_n;
  logic [2:0]    w_idx_n;
  logic          w_xfer;
  logic          w_expire;
  logic          w_accept;
  logic          w_line_n;

  assign w_accept   = TX_VALID_i & ~r_hold_full;
  assign w_expire   = (r_baud_cnt == '0);
  assign TX_READY_o = ~r_hold_full;
  assign TX_BUSY_o  = (r_state != S_IDLE) | r_hold_full;
  assign RS232_TX_o = r_tx;

  always_comb begin
    w_state_n = r_state;
    w_shift_n = r_shift;
    w_cnt_n   = r_baud_cnt;
    w_idx_n   = r_bit_idx;
    w_xfer    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_hold_full) begin
          w_xfer    = 1'b1;
          w_shift_n = r_hold_data;
          w_cnt_n   = RELOAD;
          w_state_n = S_START;
        end
      end
      S_START: begin
        if (w_expire) begin
          w_cnt_n   = RELOAD;
          w_idx_n   = 3'd0;
          w_state_n = S_DATA;
        end else begin
          w_cnt_n = r_baud_cnt - CW'(1);
        end
      end
      S_DATA: begin
        if (w_expire) begin
          w_shift_n = {1'b0, r_shift[7:1]};
          w_cnt_n   = RELOAD;
          w_idx_n   = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) w_state_n = S_STOP;
        end else begin
          w_cnt_n = r_baud_cnt - CW'(1);
        end
      end
      S_STOP: begin
        if (w_expire) begin
          // A held byte chains straight into the next start bit.
          if (r_hold_full) begin
            w_xfer    = 1'b1;
            w_shift_n = r_hold_data;
            w_cnt_n   = RELOAD;
            w_state_n = S_START;
          end else begin
            w_state_n = S_IDLE;
          end
        end else begin
          w_cnt_n = r_baud_cnt - CW'(1);
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // Line flop is loaded with the level of the state being entered.
  always_comb begin
    w_line_n = 1'b1;
    if (w_state_n == S_START)     w_line_n = 1'b0;
    else if (w_state_n == S_DATA) w_line_n = w_shift_n[0];
  end

  always_ff @(posedge CLK_i) begin
    if (!RSTn_i) begin
      r_state     <= S_IDLE;
      r_hold_data <= 8'd0;
      r_hold_full <= 1'b0;
      r_shift     <= 8'd0;
      r_baud_cnt  <= '0;
      r_bit_idx   <= 3'd0;
      r_tx        <= 1'b1;
    end else begin
      r_state    <= w_state_n;
      r_shift    <= w_shift_n;
      r_baud_cnt <= w_cnt_n;
      r_bit_idx  <= w_idx_n;
      r_tx       <= w_line_n;
      if (w_accept) begin
        r_hold_full <= 1'b1;
        r_hold_data <= TX_DATA_i;
      end else if (w_xfer) begin
        r_hold_full <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 4 clocks per bit; expected line levels come
// from hand-built 8N1 frames indexed by cycle offset from the accept edge.
module tb_uart_tx;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_line;
  logic       tx_busy;

  int checks = 0;
  int errors = 0;

  uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .CLK_i(clk), .RSTn_i(rstn), .TX_DATA_i(tx_data), .TX_VALID_i(tx_valid),
    .TX_READY_o(tx_ready), .RS232_TX_o(tx_line), .TX_BUSY_o(tx_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Frame bit n: 0 = start, 1..8 = data LSB first, 9 = stop.
  function automatic logic frame_bit(input logic [7:0] b, input int n);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    return f[n];
  endfunction

  task automatic test_reset();
    rstn = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    tick(); tick();
    checks++; if (tx_line !== 1'b1) begin errors++; $display("FAIL reset_line got=%b exp=1", tx_line); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", tx_ready); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", tx_busy); end
    rstn = 1'b1;
  endtask

  task automatic test_idle();
    int bad = 0;
    for (int i = 0; i < 1000; i++) begin
      tx_data = 8'(i * 37);
      tick();
      if (tx_line !== 1'b1 || tx_busy !== 1'b0 || tx_ready !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL idle_quiet bad_cycles=%0d exp=0", bad); end
  endtask

  task automatic test_single();
    int bad = 0;
    tx_data = 8'h55; tx_valid = 1'b1;
    tick();  // accept edge E0
    tx_valid = 1'b0; tx_data = 8'h00;
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL single_ready_e0 got=%b exp=0", tx_ready); end
    checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL single_busy_e0 got=%b exp=1", tx_busy); end
    checks++; if (tx_line !== 1'b1) begin errors++; $display("FAIL single_line_e0 got=%b exp=1", tx_line); end
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (tx_line !== frame_bit(8'h55, (k - 1) / CPB)) begin
        bad++;
        $display("FAIL single_line k=%0d got=%b exp=%b", k, tx_line, frame_bit(8'h55, (k - 1) / CPB));
      end
      if (k == 1) begin
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL single_ready_e1 got=%b exp=1", tx_ready); end
      end
      if (k == 40) begin
        checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL single_busy_e40 got=%b exp=1", tx_busy); end
      end
    end
    checks++; if (bad != 0) errors++;
    tick();
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL single_busy_e41 got=%b exp=0", tx_busy); end
    checks++; if (tx_line !== 1'b1) begin errors++; $display("FAIL single_line_e41 got=%b exp=1", tx_line); end
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    logic exp_l, exp_r;
    tx_data = 8'hA3; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (k == 1) begin tx_valid = 1'b1; tx_data = 8'h0F; end
      if (k == 2) begin tx_valid = 1'b0; tx_data = 8'hEE; end
      exp_l = (k <= 40) ? frame_bit(8'hA3, (k - 1) / CPB) : frame_bit(8'h0F, (k - 41) / CPB);
      exp_r = (k >= 2 && k <= 40) ? 1'b0 : 1'b1;
      if (tx_line !== exp_l) begin
        bad++; $display("FAIL b2b_line k=%0d got=%b exp=%b", k, tx_line, exp_l);
      end
      if (tx_ready !== exp_r) begin
        bad++; $display("FAIL b2b_ready k=%0d got=%b exp=%b", k, tx_ready, exp_r);
      end
    end
    checks++; if (bad != 0) errors++;
    tick();
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end got=%b exp=0", tx_busy); end
  endtask

  task automatic test_hold_valid();
    int bad = 0;
    logic exp_l;
    tx_data = 8'h5A; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    for (int k = 1; k <= 140; k++) begin
      tick();
      if (k == 1)  begin tx_valid = 1'b1; tx_data = 8'h96; end
      if (k == 2)  tx_data = 8'h3C;
      if (k == 20) tx_data = 8'hC3;
      if (k == 41) begin
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL hold_ready_k41 got=%b exp=1", tx_ready); end
      end
      if (k == 42) begin
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL hold_ready_k42 got=%b exp=0", tx_ready); end
        tx_valid = 1'b0;
      end
      if (k <= 40)       exp_l = frame_bit(8'h5A, (k - 1) / CPB);
      else if (k <= 80)  exp_l = frame_bit(8'h96, (k - 41) / CPB);
      else if (k <= 120) exp_l = frame_bit(8'hC3, (k - 81) / CPB);
      else               exp_l = 1'b1;
      if (tx_line !== exp_l) begin
        bad++; $display("FAIL hold_line k=%0d got=%b exp=%b", k, tx_line, exp_l);
      end
      if (k == 121) begin
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL hold_busy_k121 got=%b exp=0", tx_busy); end
      end
    end
    checks++; if (bad != 0) errors++;
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    tx_data = 8'hF0; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      tick();
      if (k == 1) begin tx_valid = 1'b1; tx_data = 8'h99; end
      if (k == 2) tx_valid = 1'b0;
      if (tx_line !== frame_bit(8'hF0, (k - 1) / CPB)) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rstmid_prefix bad_cycles=%0d exp=0", bad); end
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL rstmid_held got=%b exp=0", tx_ready); end
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    checks++; if (tx_line !== 1'b1) begin errors++; $display("FAIL rstmid_line got=%b exp=1", tx_line); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got=%b exp=1", tx_ready); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", tx_busy); end
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (tx_line !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rstmid_quiet bad_cycles=%0d exp=0", bad); end
  endtask

  task automatic test_stream();
    logic [7:0] bytes [4];
    logic [7:0] rx [4];
    int idx, bad;
    logic acc, exp_l;
    bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h81; bytes[3] = 8'h7E;
    bad = 0;
    tx_data = bytes[0]; tx_valid = 1'b1;
    tick();
    idx = 1; tx_data = bytes[1];
    for (int k = 1; k <= 161; k++) begin
      acc = tx_valid & tx_ready;
      tick();
      if (acc) begin
        idx++;
        if (idx < 4) tx_data = bytes[idx];
        else tx_valid = 1'b0;
      end
      exp_l = (k <= 160) ? frame_bit(bytes[(k - 1) / 40], ((k - 1) % 40) / CPB) : 1'b1;
      if (tx_line !== exp_l) begin
        bad++; $display("FAIL stream_line k=%0d got=%b exp=%b", k, tx_line, exp_l);
      end
      // Mid-bit sampling, as a receiver would do.
      if (k <= 160 && ((k - 1) % CPB) == 2) begin
        int f, b;
        f = (k - 1) / 40;
        b = ((k - 1) % 40) / CPB;
        if (b >= 1 && b <= 8) rx[f][b-1] = tx_line;
      end
    end
    checks++; if (bad != 0) errors++;
    checks++; if (idx != 4) begin errors++; $display("FAIL stream_accepts got=%0d exp=4", idx); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL stream_busy_end got=%b exp=0", tx_busy); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rx[i] !== bytes[i]) begin errors++; $display("FAIL stream_rx%0d got=%h exp=%h", i, rx[i], bytes[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single();
    test_back_to_back();
    test_hold_valid();
    test_reset_mid();
    test_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
